// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : Parametrised shift register with load, shift/rotate in both
//               directions and a WIDTH-cycle MSB-first burst serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_LOAD  = 3'b001;
    localparam logic [2:0] c_MODE_SHL   = 3'b010;
    localparam logic [2:0] c_MODE_SHR   = 3'b011;
    localparam logic [2:0] c_MODE_ROTL  = 3'b100;
    localparam logic [2:0] c_MODE_ROTR  = 3'b101;
    localparam logic [2:0] c_MODE_BURST = 3'b110;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_done;

    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_q     <= INIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_busy_nxt  = r_busy;
        // done is a single-cycle pulse; it only rises on the final shift edge
        w_done_nxt  = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                case (mode)
                    c_MODE_HOLD:  w_q_nxt = r_q;
                    c_MODE_LOAD:  w_q_nxt = D;
                    c_MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], sin};
                    c_MODE_SHR:   w_q_nxt = {sin, r_q[WIDTH-1:1]};
                    c_MODE_ROTL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    c_MODE_ROTR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                    c_MODE_BURST: begin
                        w_state_nxt = c_S_SHIFT;
                        w_busy_nxt  = 1'b1;
                        w_cnt_nxt   = c_CNT_LAST;
                    end
                    default:      w_q_nxt = r_q;
                endcase
            end
            c_S_SHIFT: begin
                // full-duplex: sin enters at the LSB as the MSB leaves on sout_l
                w_q_nxt = {r_q[WIDTH-2:0], sin};
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = c_S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign Q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Vector table plus burst sequences, checked via a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic [3:0] d;
        logic       sin;
        logic [3:0] q;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic [3:0] D;
    logic       sin;
    logic [3:0] Q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int   n_checks;
    int   n_fail;
    int   n_step;
    vec_t sb[$];
    vec_t tbl[14];

    universal_shift_register #(
        .WIDTH (4),
        .INIT  (4'b1001)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .D      (D),
        .sin    (sin),
        .Q      (Q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] m, input logic [3:0] d,
                                input logic s, input logic [3:0] q, input logic b,
                                input logic dn);
        vec_t v;
        v.rst = r; v.mode = m; v.d = d; v.sin = s;
        v.q = q; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %b required %b", n_step, name, act, exp);
        end
    endtask

    // Drive one edge worth of stimulus, then compare against the queued expectation.
    task automatic step(input vec_t v);
        vec_t e;
        rst  = v.rst;
        mode = v.mode;
        D    = v.d;
        sin  = v.sin;
        sb.push_back(v);
        @(posedge clk);
        #1;
        n_step++;
        e = sb.pop_front();
        cmp("Q",      Q,              e.q);
        cmp("busy",   {3'b0, busy},   {3'b0, e.busy});
        cmp("done",   {3'b0, done},   {3'b0, e.done});
        cmp("sout_l", {3'b0, sout_l}, {3'b0, e.q[3]});
        cmp("sout_r", {3'b0, sout_r}, {3'b0, e.q[0]});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_step   = 0;
        rst  = 1'b1;
        mode = 3'b000;
        D    = 4'b0000;
        sin  = 1'b0;

        //             rst  mode    D        sin   Q        busy  done
        tbl[0]  = mk(1'b1, 3'b000, 4'b0000, 1'b0, 4'b1001, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 3'b001, 4'b0110, 1'b0, 4'b0110, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 3'b010, 4'b0000, 1'b1, 4'b1101, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 3'b011, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 3'b100, 4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 3'b101, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 3'b111, 4'b1111, 1'b1, 4'b0110, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 3'b000, 4'b1111, 1'b1, 4'b0110, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 3'b001, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 3'b011, 4'b0000, 1'b1, 4'b1101, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 3'b101, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 3'b100, 4'b0000, 1'b1, 4'b1101, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 3'b010, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 3'b001, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) step(tbl[i]);

        // Burst from 1011, sin = 0,1,1,0: sout_l shows 1,0,1,1 while busy
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b1, 4'b1101, 1'b1, 1'b0));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b1, 4'b1011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b1));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0));

        // Same burst with a load request driven throughout; it must be ignored
        step(mk(1'b0, 3'b001, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b001, 4'b1111, 1'b0, 4'b0110, 1'b1, 1'b0));
        step(mk(1'b0, 3'b001, 4'b1111, 1'b1, 4'b1101, 1'b1, 1'b0));
        step(mk(1'b0, 3'b001, 4'b1111, 1'b1, 4'b1011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b001, 4'b1111, 1'b0, 4'b0110, 1'b0, 1'b1));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0));

        // Reset in the second busy cycle aborts the burst with no done pulse
        step(mk(1'b0, 3'b001, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b000, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0));
        step(mk(1'b1, 3'b000, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            step(mk(1'b0, 3'b000, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0));

        // mode=110 held: back-to-back bursts, done every 5 cycles
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b1001, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b0011, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b0111, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1111, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1110, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1100, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1));
        step(mk(1'b0, 3'b110, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0));

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
